// File: rtl/jtopl_fnum_enc_if.sv
// jtopl_fnum_enc_if: request/result handshake bundle for the fnum encoder
// Ports (signals):
//   in_valid/in_ready/phinc_target/nts   request side (master drives valid, target, nts)
//   out_valid/out_ready                  result side (master drives ready)
//   block/fnum/keycode/ovf               encoded result
interface jtopl_fnum_enc_if #(parameter int FW = 10, parameter int BW = 3);
    logic          in_valid, in_ready, nts, out_valid, out_ready, ovf;
    logic [16:0]   phinc_target;
    logic [BW-1:0] block;
    logic [FW-1:0] fnum;
    logic [3:0]    keycode;
    modport master(output in_valid, phinc_target, nts, out_ready,
                   input in_ready, out_valid, block, fnum, keycode, ovf);
    modport slave(input in_valid, phinc_target, nts, out_ready,
                  output in_ready, out_valid, block, fnum, keycode, ovf);
endinterface

// File: rtl/jtopl_fnum_enc.sv
// jtopl_fnum_enc: iterative phase-increment to block/fnum/keycode encoder
// Ports: clk, rst (sync, active-high), cen (clock enable), bus (slave side of
//   jtopl_fnum_enc_if: request in_valid/in_ready/phinc_target/nts, result
//   out_valid/out_ready/block/fnum/keycode/ovf).
// Optional: define JTOPL_FNUM_ROUND_EN to round half-up on the last dropped bit.
module jtopl_fnum_enc #(parameter int FW = 10, parameter int BW = 3) (
    input logic             clk,
    input logic             rst,
    input logic             cen,
    jtopl_fnum_enc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    localparam logic [BW-1:0] BMAX = '1;
    localparam logic [17:0]   LIM  = 18'(1) << FW;
    state_t        state_q, state_d;
    logic [17:0]   work_q, work_d;
    logic [BW-1:0] blk_q, blk_d, block_q, block_d;
    logic [FW-1:0] fnum_q, fnum_d;
    logic [3:0]    keycode_q, keycode_d;
    logic          nts_q, nts_d, ovf_q, ovf_d, valid_q, valid_d;
`ifdef JTOPL_FNUM_ROUND_EN
    logic          rbit_q, rbit_d;
    logic [FW:0]   sum;
    assign sum = work_q[FW:0] + (FW+1)'(rbit_q);
`endif
    assign bus.in_ready  = state_q == IDLE && !rst;
    assign bus.out_valid = valid_q;
    assign bus.block     = block_q;
    assign bus.fnum      = fnum_q;
    assign bus.keycode   = keycode_q;
    assign bus.ovf       = ovf_q;
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        blk_d     = blk_q;
        nts_d     = nts_q;
        block_d   = block_q;
        fnum_d    = fnum_q;
        keycode_d = keycode_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
`ifdef JTOPL_FNUM_ROUND_EN
        rbit_d    = rbit_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid) begin
                work_d  = {bus.phinc_target, 1'b0};
                blk_d   = '0;
                nts_d   = bus.nts;
`ifdef JTOPL_FNUM_ROUND_EN
                rbit_d  = 1'b0;
`endif
                state_d = NORM;
            end
            NORM: if (work_q < LIM) begin
`ifdef JTOPL_FNUM_ROUND_EN
                // rounding can carry into bit FW: renormalise, or saturate at top block
                if (sum[FW]) begin
                    fnum_d  = blk_q == BMAX ? '1 : {1'b1, {(FW-1){1'b0}}};
                    block_d = blk_q == BMAX ? blk_q : blk_q + 1'b1;
                end else begin
                    fnum_d  = sum[FW-1:0];
                    block_d = blk_q;
                end
`else
                fnum_d  = work_q[FW-1:0];
                block_d = blk_q;
`endif
                ovf_d   = 1'b0;
                state_d = DONE;
            end else if (blk_q == BMAX) begin
                fnum_d  = '1;
                block_d = BMAX;
                ovf_d   = 1'b1;
                state_d = DONE;
            end else begin
`ifdef JTOPL_FNUM_ROUND_EN
                rbit_d  = work_q[0];
`endif
                work_d  = work_q >> 1;
                blk_d   = blk_q + 1'b1;
            end
            DONE: if (valid_q && bus.out_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end else begin
                valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_q == NORM && state_d == DONE)
            keycode_d = {block_d[2:0], nts_q ? fnum_d[FW-2] : fnum_d[FW-1]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            blk_q     <= '0;
            nts_q     <= 1'b0;
            block_q   <= '0;
            fnum_q    <= '0;
            keycode_q <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
`ifdef JTOPL_FNUM_ROUND_EN
            rbit_q    <= 1'b0;
`endif
        end else if (cen) begin
            state_q   <= state_d;
            work_q    <= work_d;
            blk_q     <= blk_d;
            nts_q     <= nts_d;
            block_q   <= block_d;
            fnum_q    <= fnum_d;
            keycode_q <= keycode_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
`ifdef JTOPL_FNUM_ROUND_EN
            rbit_q    <= rbit_d;
`endif
        end
    end
endmodule

// File: tb/tb_jtopl_fnum_enc.sv
// tb_jtopl_fnum_enc: vector table, hand sequences and random checks for jtopl_fnum_enc
module tb_jtopl_fnum_enc;
    logic clk = 0, rst = 1, cen = 1;
    int   n_chk = 0, n_fail = 0;
    jtopl_fnum_enc_if bus();
    jtopl_fnum_enc dut (.clk(clk), .rst(rst), .cen(cen), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        int t; bit n; int b; int f; int k; int o; int lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Smallest block whose shifted value fits in fnum; saturate when none does.
    function automatic void model(input int t, input bit n, output int b, output int f,
                                  output int k, output int o, output int lat);
        int w;
        w = 2 * t;
        o = 0;
        b = 0;
        while (b < 7 && (w >> b) >= 1024) b++;
        if ((w >> b) >= 1024) begin
            f = 1023; o = 1; lat = 9;
        end else begin
            f = w >> b;
            lat = 2 + b;
`ifdef JTOPL_FNUM_ROUND_EN
            if (b > 0) f += (w >> (b - 1)) & 1;
            if (f == 1024) begin
                if (b < 7) begin f = 512; b++; end
                else f = 1023;
            end
`endif
        end
        k = b * 2 + (n ? (f >> 8) & 1 : (f >> 9) & 1);
    endfunction

    // Called at a negedge; returns at a negedge after the result handshake.
    task automatic conv(input int t, input bit n, input bit gate, input int hold,
                        output int lat, output int b, output int f, output int k, output int o);
        int g, iter;
        g = 0;
        while (!bus.in_ready && g < 50) begin @(negedge clk); g++; end
        bus.phinc_target = 17'(t);
        bus.nts = n;
        bus.in_valid = 1;
        cen = 1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 0;
        lat = 0;
        iter = 0;
        while (!bus.out_valid && lat < 40 && iter < 400) begin
            if (gate) cen = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (cen) lat++;
            @(negedge clk);
            iter++;
        end
        cen = 1;
        b = bus.block; f = bus.fnum; k = bus.keycode; o = bus.ovf;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold out_valid", bus.out_valid, 1);
            check("hold in_ready", bus.in_ready, 0);
            check("hold fnum", bus.fnum, f);
            check("hold block", bus.block, b);
        end
        bus.out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 0;
        check("post-handshake out_valid", bus.out_valid, 0);
        check("post-handshake fnum held", bus.fnum, f);
    endtask

    vec_t vt[$];
    int lat, b, f, k, o, eb, ef, ek, eo, el, t;
    bit n, gate;

    initial begin
        bus.in_valid = 0; bus.out_ready = 0; bus.phinc_target = 0; bus.nts = 0;
        vt.push_back('{300, 0, 0, 600, 1, 0, 2});
        vt.push_back('{1000, 0, 1, 1000, 3, 0, 3});
        vt.push_back('{1000, 1, 1, 1000, 3, 0, 3});
        vt.push_back('{'hABCD, 0, 7, 687, 15, 0, 9});
        vt.push_back('{'h10000, 0, 7, 1023, 15, 1, 9});
        vt.push_back('{0, 0, 0, 0, 0, 0, 2});
        vt.push_back('{'hFFFF, 1, 7, 1023, 15, 0, 9});
        vt.push_back('{'h1FFFF, 0, 7, 1023, 15, 1, 9});
`ifdef JTOPL_FNUM_ROUND_EN
        vt.push_back('{2047, 0, 3, 512, 7, 0, 4});
`else
        vt.push_back('{2047, 0, 2, 1023, 5, 0, 4});
`endif
        repeat (2) @(negedge clk);
        check("reset in_ready", bus.in_ready, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset fnum", bus.fnum, 0);
        check("reset block", bus.block, 0);
        check("reset keycode", bus.keycode, 0);
        check("reset ovf", bus.ovf, 0);
        rst = 0;
        #1 check("release in_ready", bus.in_ready, 1);
        @(negedge clk);

        foreach (vt[i]) begin
            conv(vt[i].t, vt[i].n, 0, 0, lat, b, f, k, o);
            check($sformatf("vec%0d block", i), b, vt[i].b);
            check($sformatf("vec%0d fnum", i), f, vt[i].f);
            check($sformatf("vec%0d keycode", i), k, vt[i].k);
            check($sformatf("vec%0d ovf", i), o, vt[i].o);
            check($sformatf("vec%0d latency", i), lat, vt[i].lat);
            check($sformatf("vec%0d in_ready", i), bus.in_ready, 1);
        end

        conv(1000, 1, 0, 5, lat, b, f, k, o);
        check("stall fnum", f, 1000);
        conv('hABCD, 0, 1, 0, lat, b, f, k, o);
        check("gated latency", lat, 9);
        check("gated fnum", f, 687);

        bus.phinc_target = 17'h0ABCD; bus.nts = 0; bus.in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        check("abort out_valid", bus.out_valid, 0);
        check("abort fnum", bus.fnum, 0);
        check("abort block", bus.block, 0);
        check("abort ovf", bus.ovf, 0);
        check("abort in_ready during rst", bus.in_ready, 0);
        rst = 0;
        #1 check("abort in_ready after rst", bus.in_ready, 1);
        @(negedge clk);
        repeat (12) @(negedge clk);
        check("abort no stale result", bus.out_valid, 0);
        conv(300, 0, 0, 0, lat, b, f, k, o);
        check("after abort fnum", f, 600);
        check("after abort latency", lat, 2);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: t = $urandom_range(0, 1023);
                1: t = $urandom_range(1024, 'hFFFF);
                default: t = $urandom_range(0, 'h1FFFF);
            endcase
            n = 1'($urandom_range(0, 1));
            gate = 1'($urandom_range(0, 1));
            model(t, n, eb, ef, ek, eo, el);
            conv(t, n, gate, 0, lat, b, f, k, o);
            check($sformatf("rnd t=%0d block", t), b, eb);
            check($sformatf("rnd t=%0d fnum", t), f, ef);
            check($sformatf("rnd t=%0d keycode", t), k, ek);
            check($sformatf("rnd t=%0d ovf", t), o, eo);
            check($sformatf("rnd t=%0d latency", t), lat, el);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
